// File: rtl/sha2_pkg.sv
// sha2_pkg: shared types and constants for the SHA-2 (32-bit word) core.
//   state_t        : controller states
//   K              : 64 round constants
//   IV_256/IV_224  : initial hash values, word 0 in the most significant slot
//   Ch/Maj/SIG0/SIG1/sig0/sig1 : round and schedule functions
package sha2_pkg;

  typedef enum logic [1:0] {IDLE, ROUNDING, FINAL, DONE} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [0:7][31:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:7][31:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] Maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] SIG0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] SIG1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// sha2_round: one combinational SHA-2 compression round.
//   a..h    : working variables in
//   k, w    : round constant and schedule word
//   na..nh  : working variables out
module sha2_round
  import sha2_pkg::*;
(
  input  logic [31:0] a, b, c, d, e, f, g, h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] na, nb, nc, nd, ne, nf, ng, nh
);
  logic [31:0] t1, t2;

  assign t1 = h + SIG1(e) + Ch(e, f, g) + k + w;
  assign t2 = SIG0(a) + Maj(a, b, c);

  assign na = t1 + t2;
  assign nb = a;
  assign nc = b;
  assign nd = c;
  assign ne = d + t1;
  assign nf = e;
  assign ng = f;
  assign nh = g;
endmodule

// File: rtl/sha2_core.sv
// sha2_core: SHA-256 / SHA-224 block compression engine, ROUNDS_PER_CYCLE
// rounds per clock, multi-block chaining.
// Optional SHA-224 support is compiled in with `define SHA2_SHA224_EN.
//   i_Clk, i_Rst   : clock, synchronous active-high reset
//   i_Text         : 512-bit padded block, word 0 in [511:480]
//   i_fStart       : block valid, taken when o_Ready is high
//   i_fFirst       : first block of a message (load IV)
//   i_Mode         : 0 SHA-256, 1 SHA-224 (first blocks only)
//   o_Ready        : core can take a block this cycle
//   o_fDone        : one-cycle pulse, o_Text just updated
//   o_Text         : chaining digest (SHA-224: [31:0] reads 0)
module sha2_core
  import sha2_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE    = 1,
  parameter bit RESET_CLEARS_DIGEST = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [511:0] i_Text,
  input  logic         i_fStart,
  input  logic         i_fFirst,
  input  logic         i_Mode,
  output logic         o_Ready,
  output logic         o_fDone,
  output logic [255:0] o_Text
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam int CYC = 64 / R;
  localparam logic [5:0] LAST = 6'(CYC - 1);

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_r
    $error("sha2_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t           state;
  logic [5:0]       cnt;
  logic [0:15][31:0] w_q, w_nx;
  logic [0:7][31:0] wv, h_q, iv_sel, h_sel;
  logic [0:7][31:0] rv [0:R];
  logic [31:0]      ext [0:15+R];
  logic             accept;

  assign accept = i_fStart & o_Ready;

`ifdef SHA2_SHA224_EN
  logic mode_q;
  assign iv_sel = i_Mode ? IV_224 : IV_256;

  always_ff @(posedge i_Clk) begin
    if (i_Rst)                  mode_q <= 1'b0;
    else if (accept & i_fFirst) mode_q <= i_Mode;
  end

  // H[7] keeps running internally; only the visible word is masked.
  assign o_Text = h_q & {{224{1'b1}}, {32{~mode_q}}};
`else
  logic unused_mode;
  assign unused_mode = i_Mode;
  assign iv_sel = IV_256;
  assign o_Text = h_q;
`endif

  assign h_sel = i_fFirst ? iv_sel : h_q;

  // Schedule window plus R new words; later new words may depend on
  // earlier ones from the same cycle, so compute in index order.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++)
      ext[16+j] = sig1(ext[14+j]) + ext[9+j] + sig0(ext[1+j]) + ext[j];
    for (int i = 0; i < 16; i++) w_nx[i] = ext[i+R];
  end

  assign rv[0] = wv;

  for (genvar j = 0; j < R; j++) begin : g_rnd
    logic [5:0]  kidx;
    logic [31:0] na, nb, nc, nd, ne, nf, ng, nh;
    assign kidx = 6'(int'(cnt) * R + j);
    sha2_round u_rnd (
      .a(rv[j][0]), .b(rv[j][1]), .c(rv[j][2]), .d(rv[j][3]),
      .e(rv[j][4]), .f(rv[j][5]), .g(rv[j][6]), .h(rv[j][7]),
      .k(K[kidx]), .w(ext[j]),
      .na(na), .nb(nb), .nc(nc), .nd(nd),
      .ne(ne), .nf(nf), .ng(ng), .nh(nh));
    assign rv[j+1] = {na, nb, nc, nd, ne, nf, ng, nh};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      o_Ready <= 1'b1;
      o_fDone <= 1'b0;
      w_q     <= '0;
      wv      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_fDone <= 1'b0;
          if (accept) begin
            state   <= ROUNDING;
            o_Ready <= 1'b0;
            cnt     <= '0;
            w_q     <= i_Text;
            wv      <= h_sel;
          end else begin
            state   <= IDLE;
            o_Ready <= 1'b1;
          end
        end
        ROUNDING: begin
          wv  <= rv[R];
          w_q <= w_nx;
          if (cnt == LAST) begin
            state <= FINAL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FINAL: begin
          state   <= DONE;
          o_fDone <= 1'b1;
          o_Ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digest: IV on first-block accept, feed-forward add at FINAL.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      if (RESET_CLEARS_DIGEST) h_q <= '0;
    end else if (accept) begin
      h_q <= h_sel;
    end else if (state == FINAL) begin
      for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv[i];
    end
  end
endmodule

// File: tb/tb_sha2_core.sv
module tb_sha2_core;
  localparam int R   = 4;
  localparam int CYC = 64 / R;

  logic         i_Clk = 1'b0;
  logic         i_Rst, i_fStart, i_fFirst, i_Mode;
  logic [511:0] i_Text;
  logic         o_Ready, o_fDone;
  logic [255:0] o_Text;

  int n_vec = 0;
  int n_bad = 0;

  logic [255:0] h_mdl;
  logic         mode_mdl;
  logic [511:0] blk_mdl;

  always #5 i_Clk = ~i_Clk;

  sha2_core #(.ROUNDS_PER_CYCLE(R)) u_dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Text(i_Text), .i_fStart(i_fStart),
    .i_fFirst(i_fFirst), .i_Mode(i_Mode), .o_Ready(o_Ready),
    .o_fDone(o_fDone), .o_Text(o_Text));

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;

  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO1  = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
  localparam logic [511:0] TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_224   = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one block onto a chaining value.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] hout;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return hout;
  endfunction

  function automatic logic [255:0] iv_of(input logic m);
`ifdef SHA2_SHA224_EN
    return m ? IV224 : IV256;
`else
    return (m & 1'b0) ? IV224 : IV256;
`endif
  endfunction

  function automatic logic [255:0] vis(input logic [255:0] h, input logic m);
    return m ? {h[255:32], 32'h0} : h;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[32*i +: 32] = $urandom;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the block is accepted at the following posedge.
  task automatic send(input logic [511:0] t, input logic f, input logic m);
    chk("ready_at_send", 256'(o_Ready), 256'(1'b1));
    i_Text = t; i_fFirst = f; i_Mode = m; i_fStart = 1'b1;
    @(posedge i_Clk);
    #1;
    i_fStart = 1'b0; i_fFirst = 1'b0; i_Mode = 1'b0;
    if (f) begin
      h_mdl = iv_of(m);
`ifdef SHA2_SHA224_EN
      mode_mdl = m;
`else
      mode_mdl = 1'b0;
`endif
    end
    blk_mdl = t;
  endtask

  // Wait for o_fDone (bounded), checking busy/stable behaviour meanwhile.
  // With spam set, i_fStart is held high with junk while the core is busy.
  task automatic finish_blk(input bit spam);
    int cyc = 0;
    bit done = 1'b0, stable = 1'b1, busy = 1'b1;
    logic [255:0] pre;
    pre = vis(h_mdl, mode_mdl);
    while (!done && cyc < 300) begin
      @(negedge i_Clk);
      cyc++;
      if (o_fDone) done = 1'b1;
      else begin
        if (o_Text !== pre) stable = 1'b0;
        if (o_Ready !== 1'b0) busy = 1'b0;
        if (spam) begin
          i_fStart = 1'b1; i_fFirst = 1'($urandom); i_Mode = 1'($urandom);
          i_Text = rand_blk();
        end
      end
    end
    i_fStart = 1'b0; i_fFirst = 1'b0; i_Mode = 1'b0;
    h_mdl = compress(h_mdl, blk_mdl);
    chk("done_seen", 256'(done), 256'(1'b1));
    chk("latency", 256'(cyc), 256'(CYC + 2));
    chk("text_stable", 256'(stable), 256'(1'b1));
    chk("busy_not_ready", 256'(busy), 256'(1'b1));
    chk("ready_in_done", 256'(o_Ready), 256'(1'b1));
    chk("digest", o_Text, vis(h_mdl, mode_mdl));
  endtask

  initial begin
    bit seen;
    i_Rst = 1'b1; i_fStart = 1'b0; i_fFirst = 1'b0; i_Mode = 1'b0; i_Text = '0;
    h_mdl = '0; mode_mdl = 1'b0; blk_mdl = '0;
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    chk("rst_ready", 256'(o_Ready), 256'(1'b1));
    chk("rst_done", 256'(o_fDone), 256'(1'b0));
    chk("rst_text", o_Text, 256'h0);

    // Non-first block straight after reset chains from zero.
    send(rand_blk(), 1'b0, 1'b0);
    finish_blk(1'b0);

    send(ABC, 1'b1, 1'b0);
    finish_blk(1'b0);
    chk("abc", o_Text, D_ABC);

    @(negedge i_Clk);
    chk("done_pulse", 256'(o_fDone), 256'(1'b0));
    send(EMPTY, 1'b1, 1'b0);
    finish_blk(1'b0);
    chk("empty", o_Text, D_EMPTY);

    // Two-block message, second accepted in the DONE cycle; mode ignored.
    send(TWO1, 1'b1, 1'b0);
    finish_blk(1'b0);
    send(TWO2, 1'b0, 1'b1);
    finish_blk(1'b0);
    chk("two_block", o_Text, D_TWO);

`ifdef SHA2_SHA224_EN
    send(ABC, 1'b1, 1'b1);
    finish_blk(1'b0);
    chk("abc224", o_Text, D_224);
`endif

    // Starts while busy are dropped.
    send(ABC, 1'b1, 1'b0);
    finish_blk(1'b1);
    chk("abc_spam", o_Text, D_ABC);

    // Reset in the cycle running rounds 28..31.
    send(ABC, 1'b1, 1'b0);
    repeat (8) @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    chk("midrst_ready", 256'(o_Ready), 256'(1'b1));
    chk("midrst_text", o_Text, 256'h0);
    h_mdl = '0; mode_mdl = 1'b0;
    seen = o_fDone;
    repeat (3 * CYC) begin
      @(negedge i_Clk);
      if (o_fDone) seen = 1'b1;
    end
    chk("midrst_no_done", 256'(seen), 256'(1'b0));
    send(ABC, 1'b1, 1'b0);
    finish_blk(1'b0);
    chk("abc_after_rst", o_Text, D_ABC);

    // Random messages: random first/mode flags and gaps.
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge i_Clk);
      send(rand_blk(), (n == 0) ? 1'b1 : 1'($urandom_range(0, 2) == 0), 1'($urandom));
      finish_blk(1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
